// File: rtl/point_extractor.sv
// point_extractor: scans a 1-bit pixel mask stream and recovers the (x,y)
// coordinates of set pixels. Up to N_POINTS coordinates are buffered per
// frame, then drained after the frame-end beat over a valid/ready stream.
// A one-cycle frame_done pulse carries the point count and overflow flag.
//
// Ports:
//   clk_in, rst_in           clock, asynchronous active-low reset
//   hcount_in, vcount_in     coordinates of the current pixel beat
//   data_valid_in            pixel beat qualifier
//   pixel_in                 mask bit (1 = point pixel)
//   x_out, y_out             drained point coordinates
//   point_valid_out          x_out/y_out valid
//   point_ready_in           downstream accepts the point
//   point_last_out           final point of the frame (qualified by valid)
//   frame_done_out           one-cycle pulse after the drain completes
//   count_out                points in the frame (valid with frame_done_out)
//   overflow_out             set pixels were dropped (valid with frame_done_out)
module point_extractor #(
    parameter int unsigned N_POINTS = 8,
    parameter int unsigned H_LAST   = 1279,
    parameter int unsigned V_LAST   = 719
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [10:0]                     hcount_in,
    input  logic [9:0]                      vcount_in,
    input  logic                            data_valid_in,
    input  logic                            pixel_in,
    output logic [10:0]                     x_out,
    output logic [9:0]                      y_out,
    output logic                            point_valid_out,
    input  logic                            point_ready_in,
    output logic                            point_last_out,
    output logic                            frame_done_out,
    output logic [$clog2(N_POINTS+1)-1:0]   count_out,
    output logic                            overflow_out
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = $clog2(N_POINTS + 1);
    localparam int unsigned AW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wr_idx_q, wr_idx_d;
    logic [CW-1:0]   rd_idx_q, rd_idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            ovf_pending_q, ovf_pending_d;
    point_t          pt_mem [N_POINTS];

    logic            wr_en;
    logic            set_px;
    logic            frame_end;
    logic            xfer;
    point_t          new_pt;
    point_t          rd_pt;

    logic            valid_d;
    logic            last_d;
    logic            done_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic [CW-1:0]   count_out_d;
    logic            overflow_out_d;

    // Beat decode; cycles without data_valid_in are invisible to the block
    always_comb begin
        set_px    = data_valid_in && pixel_in;
        frame_end = data_valid_in && (hcount_in == XW'(H_LAST))
                                  && (vcount_in == YW'(V_LAST));
        xfer      = point_valid_out && point_ready_in;
        new_pt    = '{x: hcount_in, y: vcount_in};
    end

    // Next-state, index bookkeeping and next output values
    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        ovf_pending_d = ovf_pending_q;
        wr_en         = 1'b0;

        unique case (state_q)
            CAPTURE: begin
                if (set_px) begin
                    if (wr_idx_q < CW'(N_POINTS)) begin
                        wr_en    = 1'b1;
                        wr_idx_d = wr_idx_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                // The frame-end pixel itself is captured before the count latches
                if (frame_end) begin
                    count_d  = wr_idx_d;
                    rd_idx_d = '0;
                    state_d  = (wr_idx_d != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                // Set pixels here belong to the next frame and cannot be stored
                if (set_px) begin
                    ovf_pending_d = 1'b1;
                end
                if (xfer) begin
                    rd_idx_d = rd_idx_q + CW'(1);
                    if (point_last_out) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d       = CAPTURE;
                wr_idx_d      = '0;
                rd_idx_d      = '0;
                overflow_d    = ovf_pending_q || set_px;
                ovf_pending_d = 1'b0;
            end
            default: begin
                state_d = CAPTURE;
            end
        endcase

        // Forward the point being written when the drain starts on that same edge
        rd_pt = pt_mem[AW'(rd_idx_d)];
        if (wr_en && (wr_idx_q == rd_idx_d)) begin
            rd_pt = new_pt;
        end

        valid_d        = (state_d == DRAIN);
        x_d            = valid_d ? rd_pt.x : '0;
        y_d            = valid_d ? rd_pt.y : '0;
        last_d         = valid_d && (rd_idx_d == (count_d - CW'(1)));
        done_d         = (state_d == DONE);
        count_out_d    = done_d ? count_d : '0;
        overflow_out_d = done_d && overflow_d;
    end

    // State and bookkeeping registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= CAPTURE;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            ovf_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            ovf_pending_q <= ovf_pending_d;
        end
    end

    // Point storage; contents only matter below wr_idx, so no reset
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            pt_mem[AW'(wr_idx_q)] <= new_pt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            point_valid_out <= 1'b0;
            x_out           <= '0;
            y_out           <= '0;
            point_last_out  <= 1'b0;
            frame_done_out  <= 1'b0;
            count_out       <= '0;
            overflow_out    <= 1'b0;
        end else begin
            point_valid_out <= valid_d;
            x_out           <= x_d;
            y_out           <= y_d;
            point_last_out  <= last_d;
            frame_done_out  <= done_d;
            count_out       <= count_out_d;
            overflow_out    <= overflow_out_d;
        end
    end

endmodule
